fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Parametrised fetch stage with a prefetch queue. Issues sequential word
//  reads to IMEM over a valid/ready request channel. Buffers in-order
//  responses as {pc, insn} entries and presents the oldest one to DECODE.
//  Branch redirects from EXECUTE flush the queue and discard stale in-flight
//  responses, which decouples variable IMEM latency from the pipeline.
// PARAMETERS
//  BASE_ADDR   32'h80020000  reset fetch PC
//  ADDR_W      32            PC / address width
//  INSN_W      32            instruction width
//  DEPTH       4             queue entries; power of 2, >= 2; also the in-flight cap
//  WORD_SIZE   2'b00         value driven on mem_access_size (1 word)
// PORTS
//  clock            in   1       rising-edge clock
//  reset_n          in   1       asynchronous, active-low reset
//  stall            in   1       DECODE not accepting this cycle
//  do_branch        in   1       redirect request from EXECUTE
//  pc_effective     in   ADDR_W  redirect target
//  mem_req_valid    out  1       read request valid
//  mem_req_ready    in   1       IMEM accepts request
//  mem_addr         out  ADDR_W  request address (= fetch_pc)
//  mem_rw           out  1       constant 1 (read)
//  mem_access_size  out  2       constant WORD_SIZE
//  mem_resp_valid   in   1       read data valid; in order, 1 per request
//  mem_resp_data    in   INSN_W  read data
//  insn_valid       out  1       queue head valid
//  pc_out           out  ADDR_W  head PC; 0 when !insn_valid
//  insn_out         out  INSN_W  head instruction; 0 when !insn_valid
// BEHAVIOUR
//  - Reset (async): fetch_pc = resp_pc = BASE_ADDR; count = inflight = discard = 0.
//    Outputs: insn_valid 0, pc_out 0, insn_out 0, mem_req_valid 0.
//  - Issue: mem_req_valid = !do_branch && (count + inflight < DEPTH).
//    On valid && ready: fetch_pc += 4, inflight++.
//    mem_addr is stable while valid && !ready.
//  - Response, when mem_resp_valid: inflight--.
//    If discard != 0: discard--, data dropped.
//    Else push {resp_pc, mem_resp_data} and resp_pc += 4.
//    Response with inflight == 0 is ignored (assertion fires).
//  - Pop: when insn_valid && !stall. A response pushed into an empty queue
//    appears at the head the next cycle (1-cycle resp->DECODE latency).
//  - Push and pop in the same cycle leave count unchanged.
//    The credit rule guarantees a push never meets a full queue.
//  - Redirect (do_branch=1) has priority over stall, pop and issue. Next state:
//    count = 0; fetch_pc = resp_pc = {pc_effective[ADDR_W-1:2], 2'b00};
//    inflight = inflight - resp_valid; discard = inflight - resp_valid
//    (any response arriving in the redirect cycle is dropped).
//    No request is issued in the redirect cycle.
//  - Back-to-back redirects are legal: each one re-targets, and discard
//    accumulates correctly because it is recomputed from inflight.
//  - Widths: count/inflight/discard are $clog2(DEPTH)+1 bits.
//    PCs wrap modulo 2^ADDR_W; 32'hFFFFFFFC + 4 -> 0.
//  - Stall with no redirect: the queue holds and prefetch continues until
//    count + inflight == DEPTH.
// STRUCTURE
//  - fetch_pkg: BASE_ADDR default, WORD_SIZE, INSN_W, ADDR_W,
//    typedef fetch_entry_t {pc, insn}.
//  - Sub-module fetch_fifo: sync FIFO of fetch_entry_t, DEPTH entries,
//    push/pop/flush, count out; head output is zeroed when empty.
//  - Top level holds fetch_pc, resp_pc, the inflight/discard counters
//    and the issue logic.
// TESTING
//  1 Reset release, ready=1, 2-cycle IMEM latency, no stall -> requests at
//    80020000, ..04, ..08; DECODE sees pc_out in that order, one per cycle
//    once filled.
//  2 stall held 10 cycles, DEPTH=4 -> exactly 4 requests issued, then
//    mem_req_valid=0. On release, 4 entries drain in order, then issue resumes.
//  3 do_branch with inflight=3 and pc_effective=80020103 -> fetch_pc=80020100,
//    next 3 responses dropped, first delivered entry has pc_out=80020100.
//  4 Response arriving in the redirect cycle plus a second redirect 1 cycle
//    later -> no stale insn delivered; final pc_out equals second target.
//  5 mem_req_ready=0 for 5 cycles -> mem_addr stable and mem_req_valid held;
//    exactly one request is counted when ready rises.
//  6 reset_n low mid-burst with queue non-empty -> outputs 0 immediately
//    (async); after release, fetch restarts at BASE_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults and queue entry type for the fetch stage
package fetch_pkg;
    localparam int          ADDR_W    = 32;
    localparam int          INSN_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h8002_0000;
    localparam logic [1:0]  WORD_SIZE = 2'b00;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of {pc, insn} entries
// Head reads as all-zero while empty so DECODE never sees stale data.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  entry_t        din,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t        slots [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL) || pop_ok);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) slots[wr_ptr] <= din;
    end

    assign head = (count != '0) ? slots[rd_ptr] : '0;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - sequential IMEM prefetch with redirect flush
// Credits (queued + in-flight) never exceed DEPTH, so a response always has room.
module fetch_prefetch_queue #(
    parameter int                ADDR_W    = fetch_pkg::ADDR_W,
    parameter int                INSN_W    = fetch_pkg::INSN_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = fetch_pkg::BASE_ADDR,
    parameter int                DEPTH     = 4,
    parameter logic [1:0]        WORD_SIZE = fetch_pkg::WORD_SIZE
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] pc_effective,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [1:0]        mem_access_size,
    input  logic              mem_resp_valid,
    input  logic [INSN_W-1:0] mem_resp_data,
    output logic              insn_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INSN_W-1:0] insn_out
);
    localparam int                CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     count;
    logic              issue;
    logic              resp_ok;
    logic              push;
    logic              pop;
    logic              unused_bits;
    entry_t            head;
    entry_t            din;

    assign target      = {pc_effective[ADDR_W-1:2], 2'b00};
    assign unused_bits = ^pc_effective[1:0];

    assign mem_req_valid   = reset_n && !do_branch && ((count + inflight) < DEPTH_C);
    assign mem_addr        = fetch_pc;
    assign mem_rw          = 1'b1;
    assign mem_access_size = WORD_SIZE;

    assign issue   = mem_req_valid && mem_req_ready;
    assign resp_ok = mem_resp_valid && (inflight != '0);
    assign push    = resp_ok && (discard == '0) && !do_branch;
    assign pop     = insn_valid && !stall && !do_branch;
    assign din     = '{pc: resp_pc, insn: mem_resp_data};

    // A redirect re-arms discard from inflight so back-to-back redirects stay exact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= BASE_ADDR;
            resp_pc  <= BASE_ADDR;
            inflight <= '0;
            discard  <= '0;
        end else if (do_branch) begin
            fetch_pc <= target;
            resp_pc  <= target;
            inflight <= inflight - CW'(resp_ok);
            discard  <= inflight - CW'(resp_ok);
        end else begin
            if (issue) fetch_pc <= fetch_pc + STEP;
            if (push)  resp_pc  <= resp_pc + STEP;
            inflight <= inflight + CW'(issue) - CW'(resp_ok);
            if (resp_ok && (discard != '0)) discard <= discard - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (do_branch),
        .push    (push),
        .din     (din),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    assign insn_valid = (count != '0);
    assign pc_out     = head.pc;
    assign insn_out   = head.insn;

    resp_without_request: assert property (@(posedge clock) disable iff (!reset_n)
        mem_resp_valid |-> (inflight != '0));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;
    localparam logic [31:0] BASE = 32'h8002_0000;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n, stall, do_branch, mem_req_ready, mem_resp_valid;
    logic [31:0] pc_effective, mem_resp_data;
    logic        mem_req_valid, mem_rw, insn_valid;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_addr, pc_out, insn_out;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          cyc, lat, n_acc;
    int          n_cmp, n_bad;
    logic [31:0] acc_addr;

    always #5 clock = ~clock;

    fetch_prefetch_queue dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .do_branch       (do_branch),
        .pc_effective    (pc_effective),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_addr        (mem_addr),
        .mem_rw          (mem_rw),
        .mem_access_size (mem_access_size),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .insn_valid      (insn_valid),
        .pc_out          (pc_out),
        .insn_out        (insn_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request handshake, then the IMEM model answers
    // in order, lat cycles after acceptance, with data = ~address.
    task automatic cycle();
        logic        a;
        logic [31:0] ad;
        #1;
        a  = mem_req_valid && mem_req_ready;
        ad = mem_addr;
        @(posedge clock);
        cyc++;
        acc_addr = NONE;
        if (a) begin
            pend.push_back('{ad, cyc + lat - 1});
            n_acc++;
            acc_addr = ad;
        end
        @(negedge clock);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = ~pend[0].addr;
            void'(pend.pop_front());
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        stall          = 1'b0;
        do_branch      = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        pend.delete();
        lat   = 2;
        n_acc = 0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; lat = 2; n_acc = 0;
        acc_addr = NONE; pc_effective = '0;
        reset_n = 1'b0; stall = 1'b0; do_branch = 1'b0; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = '0;

        // reset state
        #12;
        chk("rst_insn_valid", 32'(insn_valid), 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_insn_out", insn_out, 32'h0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd1);
        chk("rst_size", 32'(mem_access_size), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: streaming, 2-cycle IMEM
        cycle(); chk("t1_req0", acc_addr, 32'h8002_0000);
        cycle(); chk("t1_req1", acc_addr, 32'h8002_0004);
        cycle(); chk("t1_req2", acc_addr, 32'h8002_0008);
        chk("t1_head0", pc_out, 32'h8002_0000);
        chk("t1_insn0", insn_out, 32'h7FFD_FFFF);
        cycle(); chk("t1_head1", pc_out, 32'h8002_0004);
        cycle(); chk("t1_head2", pc_out, 32'h8002_0008);

        // 2: stall fills credits, then drain and resume
        do_reset();
        stall = 1'b1;
        repeat (10) cycle();
        chk("t2_req_count", 32'(n_acc), 32'd4);
        chk("t2_req_valid_low", 32'(mem_req_valid), 32'd0);
        chk("t2_head_held", pc_out, 32'h8002_0000);
        stall = 1'b0;
        cycle(); chk("t2_drain1", pc_out, 32'h8002_0004);
        cycle(); chk("t2_drain2", pc_out, 32'h8002_0008);
        chk("t2_resume", acc_addr, 32'h8002_0010);
        cycle(); chk("t2_drain3", pc_out, 32'h8002_000C);
        cycle(); chk("t2_next", pc_out, 32'h8002_0010);

        // 3: redirect with 3 in flight, unaligned target
        do_reset();
        lat = 4;
        repeat (3) cycle();
        do_branch = 1'b1;
        pc_effective = 32'h8002_0103;
        #1 chk("t3_no_req_on_branch", 32'(mem_req_valid), 32'd0);
        cycle();
        do_branch = 1'b0;
        chk("t3_fetch_pc", mem_addr, 32'h8002_0100);
        for (int i = 0; i < 4; i++) begin
            cycle(); chk("t3_stale_dropped", 32'(insn_valid), 32'd0);
        end
        cycle();
        chk("t3_first_pc", pc_out, 32'h8002_0100);
        chk("t3_first_insn", insn_out, 32'h7FFD_FEFF);

        // 4: response in redirect cycle, second redirect right after
        do_reset();
        cycle(); cycle();
        do_branch = 1'b1;
        pc_effective = 32'h8003_0000;
        cycle(); chk("t4_v_a", 32'(insn_valid), 32'd0);
        pc_effective = 32'h8004_0008;
        cycle();
        do_branch = 1'b0;
        chk("t4_v_b", 32'(insn_valid), 32'd0);
        chk("t4_fetch_pc", mem_addr, 32'h8004_0008);
        cycle(); chk("t4_req", acc_addr, 32'h8004_0008);
        chk("t4_v_c", 32'(insn_valid), 32'd0);
        cycle(); chk("t4_v_d", 32'(insn_valid), 32'd0);
        cycle();
        chk("t4_final_pc", pc_out, 32'h8004_0008);
        chk("t4_final_insn", insn_out, 32'h7FFB_FFF7);

        // 5: IMEM back-pressure
        do_reset();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_valid_held", 32'(mem_req_valid), 32'd1);
            chk("t5_addr_stable", mem_addr, 32'h8002_0000);
        end
        chk("t5_none_taken", 32'(n_acc), 32'd0);
        mem_req_ready = 1'b1;
        cycle();
        chk("t5_one_taken", 32'(n_acc), 32'd1);
        chk("t5_next_addr", mem_addr, 32'h8002_0004);
        mem_req_ready = 1'b0;
        cycle(); cycle();
        chk("t5_head", pc_out, 32'h8002_0000);
        chk("t5_addr_hold", mem_addr, 32'h8002_0004);

        // 6: asynchronous reset with a full queue
        do_reset();
        stall = 1'b1;
        repeat (6) cycle();
        chk("t6_full", 32'(insn_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_insn_valid", 32'(insn_valid), 32'd0);
        chk("t6_pc_out", pc_out, 32'h0);
        chk("t6_insn_out", insn_out, 32'h0);
        chk("t6_req_valid", 32'(mem_req_valid), 32'd0);
        do_reset();
        cycle(); chk("t6_restart", acc_addr, 32'h8002_0000);

        // 7: PC wrap at top of address space
        do_reset();
        do_branch = 1'b1;
        pc_effective = 32'hFFFF_FFFE;
        cycle();
        do_branch = 1'b0;
        cycle(); chk("t7_req_top", acc_addr, 32'hFFFF_FFFC);
        cycle(); chk("t7_req_wrap", acc_addr, 32'h0000_0000);
        cycle(); chk("t7_head_top", pc_out, 32'hFFFF_FFFC);
        cycle();
        chk("t7_wrap_valid", 32'(insn_valid), 32'd1);
        chk("t7_wrap_pc", pc_out, 32'h0000_0000);
        chk("t7_wrap_insn", insn_out, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
